// File: rtl/tohost_monitor.sv
// tohost_monitor: watches data-memory stores for the tohost
// pass/fail mailbox and the console character channel.
// Params : TOHOST_ADDR, CONSOLE_ADDR, TIMEOUT_CYCLES, CNT_W
// Inputs : sys_clk, sys_rst_n (sync, active-low),
//          mem_we[3:0], mem_addr[31:0], mem_wdata[31:0]
// Outputs: status[1:0] (0 RUN,1 PASS,2 FAIL,3 TIMEOUT),
//          done, fail_code[30:0], cycle_count[CNT_W-1:0],
//          char_valid, char_data[7:0]
// Macro  : TOHOST_MONITOR_TIMEOUT_EN compiles in the watchdog.
module tohost_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter logic [31:0] CONSOLE_ADDR   = 32'h0000_1004,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [3:0]       mem_we,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  output logic [1:0]       status,
  output logic             done,
  output logic [30:0]      fail_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic             char_valid,
  output logic [7:0]       char_data
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_PASS    = 2'd1,
    S_FAIL    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] TO_LIM =
    CNT_W'(TIMEOUT_CYCLES);

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic [30:0]      fc_q, fc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             cv_q;
  logic [7:0]       cd_q;

  logic store, th_ev, con_ev;
  logic wd_one, wd_zero, to_hit;

  assign store   = |mem_we;
  assign th_ev   = store && (mem_addr == TOHOST_ADDR);
  assign con_ev  = store && (mem_addr == CONSOLE_ADDR);
  assign wd_one  = (mem_wdata == 32'd1);
  assign wd_zero = (mem_wdata == 32'd0);

  // Saturating increment: holds at all-ones.
  assign cnt_inc = (&cnt_q) ? cnt_q
                            : cnt_q + CNT_W'(1);

  // Timeout fires on the edge the count reaches the limit.
  assign to_hit = (cnt_inc == TO_LIM);

`ifndef TOHOST_MONITOR_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = to_hit;
`endif

  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    cnt_d   = cnt_q;
    if (state_q == S_RUN) begin
      cnt_d = cnt_inc;
      // Mailbox write outranks the watchdog.
      if (th_ev && wd_one) begin
        state_d = S_PASS;
      end else if (th_ev && !wd_zero) begin
        state_d = S_FAIL;
        fc_d    = mem_wdata[31:1];
      end
`ifdef TOHOST_MONITOR_TIMEOUT_EN
      else if (to_hit) begin
        state_d = S_TIMEOUT;
      end
`endif
    end
    done_d = (state_d != S_RUN);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= S_RUN;
      done_q  <= 1'b0;
      fc_q    <= '0;
      cnt_q   <= '0;
      cv_q    <= 1'b0;
      cd_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      fc_q    <= fc_d;
      cnt_q   <= cnt_d;
      cv_q    <= con_ev;
      if (con_ev) begin
        cd_q <= mem_wdata[7:0];
      end
    end
  end

  assign status      = state_q;
  assign done        = done_q;
  assign fail_code   = fc_q;
  assign cycle_count = cnt_q;
  assign char_valid  = cv_q;
  assign char_data   = cd_q;

endmodule

// File: tb/tb_tohost_monitor.sv
// tb_tohost_monitor: directed table, corner sequences and
// randomized stores checked against a reference model.
module tb_tohost_monitor;

  localparam int CW = 5;
  localparam int TO = 10;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [31:0] TH = 32'h0000_1000;
  localparam logic [31:0] CA = 32'h0000_1004;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    we = '0;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic [1:0]    status;
  logic          done;
  logic [30:0]   fail_code;
  logic [CW-1:0] cycle_count;
  logic          char_valid;
  logic [7:0]    char_data;

  tohost_monitor #(
    .TOHOST_ADDR   (TH),
    .CONSOLE_ADDR  (CA),
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (CW)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .mem_we     (we),
    .mem_addr   (addr),
    .mem_wdata  (wdata),
    .status     (status),
    .done       (done),
    .fail_code  (fail_code),
    .cycle_count(cycle_count),
    .char_valid (char_valid),
    .char_data  (char_data)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  int          m_st;
  logic [30:0] m_fc;
  int          m_cnt;
  logic        m_cv;
  logic [7:0]  m_cd;
  bit          m_cdchk;

  typedef struct {
    logic        r;
    logic [3:0]  w;
    logic [31:0] a;
    logic [31:0] d;
    int          st;
    logic [30:0] fc;
    int          cnt;
    logic        cv;
    logic [7:0]  cd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic r, logic [3:0] w, logic [31:0] a,
    logic [31:0] d, int st, logic [30:0] fc,
    int cnt, logic cv, logic [7:0] cd);
    vec_t v;
    v.r = r; v.w = w; v.a = a; v.d = d;
    v.st = st; v.fc = fc; v.cnt = cnt;
    v.cv = cv; v.cd = cd;
    return v;
  endfunction

  task automatic chk(input string nm, input int est,
                     input logic [30:0] efc, input int ecnt,
                     input logic ecv, input logic [7:0] ecd,
                     input bit cdchk);
    nvec++;
    if (status !== 2'(est) || done !== (est != 0) ||
        fail_code !== efc || cycle_count !== CW'(ecnt) ||
        char_valid !== ecv ||
        (cdchk && char_data !== ecd)) begin
      nerr++;
      $display("FAIL %s: got st=%0d done=%0b fc=%h cnt=%0d cv=%0b cd=%h ; want st=%0d done=%0b fc=%h cnt=%0d cv=%0b cd=%h",
               nm, status, done, fail_code, cycle_count,
               char_valid, char_data, est, est != 0, efc,
               ecnt, ecv, ecd);
    end
  endtask

  task automatic drive_edge(input logic r, input logic [3:0] w,
                            input logic [31:0] a,
                            input logic [31:0] d);
    rst_n = r; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_edge(1, 0, 0, 0);
  endtask

  // Behavioural rules applied once per rising edge.
  task automatic model_edge(input logic r, input logic [3:0] w,
                            input logic [31:0] a,
                            input logic [31:0] d);
    bit th, cn;
    int nc;
    th = (w != 0) && (a == TH);
    cn = (w != 0) && (a == CA);
    if (!r) begin
      m_st = 0; m_fc = '0; m_cnt = 0; m_cv = 0; m_cd = '0;
      m_cdchk = 1;
      return;
    end
    if (m_st == 0) begin
      nc = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
      if (th && d == 1) m_st = 1;
      else if (th && d != 0) begin
        m_st = 2;
        m_fc = d >> 1;
      end
`ifdef TOHOST_MONITOR_TIMEOUT_EN
      else if (nc == TO) m_st = 3;
`endif
      m_cnt = nc;
    end
    m_cv = cn;
    if (cn) m_cd = d[7:0];
    m_cdchk = cn;
  endtask

  task automatic step(input logic r, input logic [3:0] w,
                      input logic [31:0] a,
                      input logic [31:0] d);
    drive_edge(r, w, a, d);
    model_edge(r, w, a, d);
    chk("rand", m_st, m_fc, m_cnt, m_cv, m_cd, m_cdchk);
  endtask

  initial begin
    logic        r;
    logic [3:0]  w;
    logic [31:0] a, d;

    // Directed table
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, i, 0, 0));
    tbl.push_back(mk(1, 4'hF, TH, 1, 1, 0, 6, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 6, 0, 0));
    tbl.push_back(mk(1, 4'hF, TH, 7, 1, 0, 6, 0, 0));
    tbl.push_back(mk(1, 4'hF, CA, 32'h41, 1, 0, 6, 1, 8'h41));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 6, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h1, TH, 7, 2, 3, 1, 0, 0));
    tbl.push_back(mk(1, 4'hF, TH, 1, 2, 3, 1, 0, 0));
    tbl.push_back(mk(1, 4'h2, CA, 32'h48, 2, 3, 1, 1, 8'h48));
    tbl.push_back(mk(1, 4'hF, CA, 32'h69, 2, 3, 1, 1, 8'h69));
    tbl.push_back(mk(1, 0, 0, 0, 2, 3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 2, 0, 0));
    tbl.push_back(mk(1, 4'hF, TH, 0, 0, 0, 3, 0, 0));
    tbl.push_back(mk(1, 4'hF, 32'h1008, 1, 0, 0, 4, 0, 0));
    tbl.push_back(mk(1, 4'h0, TH, 1, 0, 0, 5, 0, 0));
    tbl.push_back(mk(0, 4'hF, TH, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, CA, 32'h55, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'hF, 32'h0001_1000, 1,
                     0, 0, 2, 0, 0));
    tbl.push_back(mk(1, 4'hF, TH, 32'hFFFF_FFFF,
                     2, 31'h7FFF_FFFF, 3, 0, 0));

    foreach (tbl[i]) begin
      drive_edge(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d", i), tbl[i].st, tbl[i].fc,
          tbl[i].cnt, tbl[i].cv, tbl[i].cd,
          !tbl[i].r || tbl[i].cv);
    end

`ifdef TOHOST_MONITOR_TIMEOUT_EN
    drive_edge(0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      drive_edge(1, 0, 0, 0);
      chk("to_pre", 0, 0, i, 0, 0, 0);
    end
    drive_edge(1, 0, 0, 0);
    chk("to_hit", 3, 0, TO, 0, 0, 0);
    drive_edge(1, 4'hF, TH, 1);
    chk("to_term", 3, 0, TO, 0, 0, 0);
    drive_edge(0, 0, 0, 0);
    idle(9);
    drive_edge(1, 4'hF, TH, 1);
    chk("to_prio_pass", 1, 0, TO, 0, 0, 0);
    drive_edge(0, 0, 0, 0);
    idle(9);
    drive_edge(1, 4'hF, TH, 7);
    chk("to_prio_fail", 2, 3, TO, 0, 0, 0);
    drive_edge(0, 0, 0, 0);
    idle(9);
    drive_edge(1, 4'hF, TH, 0);
    chk("to_zero_store", 3, 0, TO, 0, 0, 0);
`else
    drive_edge(0, 0, 0, 0);
    idle(TO);
    chk("no_timeout", 0, 0, TO, 0, 0, 0);
    idle(CMAX - TO);
    chk("sat_reach", 0, 0, CMAX, 0, 0, 0);
    idle(9);
    chk("sat_hold", 0, 0, CMAX, 0, 0, 0);
    drive_edge(1, 4'hF, TH, 1);
    chk("sat_pass", 1, 0, CMAX, 0, 0, 0);
`endif

    // Randomized phase against the model
    step(0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 99) != 0);
      w = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      case ($urandom_range(0, 5))
        0, 1:    a = TH;
        2, 3:    a = CA;
        4:       a = 32'h0000_1008;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0, 1:    d = 32'd0;
        2:       d = 32'd1;
        3:       d = $urandom_range(2, 5);
        default: d = $urandom;
      endcase
      step(r, w, a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
